// File: rtl/jk_drv_pkg.sv
// Shared definitions for the JK bank driver: FSM state encoding and the
// two-bit {J,K} excitation codes.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } drv_state_e;

    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] RESET  = 2'b01;
    localparam logic [1:0] SET    = 2'b10;
    localparam logic [1:0] TOGGLE = 2'b11;

    // {J,K} needed to move one flip-flop from q_cur to q_tgt.
    function automatic logic [1:0] jk_code(input logic q_cur, input logic q_tgt,
                                           input logic tog);
        logic [1:0] code;
        code = HOLD;
        if (q_cur != q_tgt) begin
            code = tog ? TOGGLE : (q_tgt ? SET : RESET);
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational excitation for a single JK flip-flop.
module jk_excite
    import jk_drv_pkg::*;
(
    input  logic q_cur,
    input  logic q_tgt,
    input  logic tog,
    output logic j,
    output logic k
);

    logic [1:0] code;

    always_comb begin
        code = jk_code(q_cur, q_tgt, tog);
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Walks a bank of JK flip-flops to a captured target one bit per cycle,
// LSB first, then verifies the bank and reports done/err.
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             use_toggle,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    drv_state_e       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             tog_q, tog_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ex_j, ex_k;

    jk_excite u_excite (
        .q_cur (q_fb[idx_q]),
        .q_tgt (tgt_q[idx_q]),
        .tog   (tog_q),
        .j     (ex_j),
        .k     (ex_k)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        tog_d   = tog_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    tog_d   = use_toggle;
                    idx_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                done_d  = 1'b1;
                err_d   = (q_fb != tgt_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the excitation in the same cycle, before the next edge.
    always_comb begin
        j = '0;
        k = '0;
        if (!rst && state_q == DRIVE) begin
            j[idx_q] = ex_j;
            k[idx_q] = ex_k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tgt_q   <= '0;
            tog_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            tog_q   <= tog_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == DRIVE) || (state_q == CHECK);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of JK flip-flops in the driven bank.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to move the bank to target; sampled only in IDLE.
REQ-005 The block SHALL have port target, input, WIDTH bits: the desired bank value, captured when start is accepted.
REQ-006 The block SHALL have port use_toggle, input, 1 bit: when high, differing bits are driven with toggle (11) instead of set/reset; captured with target.
REQ-007 The block SHALL have port q_fb, input, WIDTH bits: live q outputs of the JK bank.
REQ-008 The block SHALL have port j, output, WIDTH bits: J excitation, one bit per flip-flop.
REQ-009 The block SHALL have port k, output, WIDTH bits: K excitation, one bit per flip-flop.
REQ-010 The block SHALL have port busy, output, 1 bit: high in DRIVE and CHECK.
REQ-011 The block SHALL have port done, output, 1 bit: registered, one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: registered, valid only with done; high if the bank did not reach target.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE and CHECK.
REQ-014 IDLE with start=1 SHALL capture target into tgt_r and use_toggle into tog_r, set idx=0, and go to DRIVE.
REQ-015 DRIVE SHALL last exactly WIDTH cycles, one bit per cycle, LSB first, with idx incrementing each cycle; after idx=WIDTH-1 the FSM goes to CHECK.
REQ-016 In DRIVE, only bit idx SHALL be excited; all other j/k bits SHALL be 00.
REQ-017 Bit idx excitation SHALL be combinational from q_fb[idx] and tgt_r[idx]: equal -> 00; 0->1 -> 10; 1->0 -> 01; differing with tog_r=1 -> 11.
REQ-018 In CHECK and IDLE, j and k SHALL be all zero.
REQ-019 CHECK SHALL last one cycle and compare q_fb with tgt_r; next cycle done=1, err=(q_fb!=tgt_r), and the state is IDLE.
REQ-020 Latency: start sampled in cycle 0 -> DRIVE cycles 1..WIDTH -> CHECK cycle WIDTH+1 -> done in cycle WIDTH+2.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start in the same cycle as done=1 SHALL be accepted, giving back-to-back operations with no gap cycle.
REQ-023 target or use_toggle changes after capture SHALL NOT affect an operation in flight.
REQ-024 err SHALL be 0 whenever done=0.

Reset
REQ-025 While rst=1, j and k SHALL be forced to all zero combinationally in the same cycle.
REQ-026 At a clock edge with rst=1, the block SHALL set: state IDLE, idx 0, tgt_r 0, tog_r 0, busy 0, done 0, err 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse; rst SHALL take priority over start.

Structure
REQ-028 Shared package jk_drv_pkg SHALL contain the state encoding (IDLE/DRIVE/CHECK) and excitation constants HOLD=00, RESET=01, SET=10, TOGGLE=11.
REQ-029 Sub-module jk_excite SHALL be combinational: inputs q_cur, q_tgt, tog; outputs j, k per REQ-017; one instance used for bit idx.
REQ-030 The bench SHALL close the loop through WIDTH instances of the team's jk_ff, sharing clk and rst.

Verification (WIDTH=4, bank of jk_ff)
REQ-031 Reset, bank=0000, start with target=1010, use_toggle=0 -> jk per DRIVE cycle: 00, 10(bit1), 00, 10(bit3); done in cycle 6; err=0; bank=1010.
REQ-032 Bank=1010, target=0101, use_toggle=1 -> each DRIVE cycle excites its bit with 11; bank=0101; done with err=0.
REQ-033 Bank=0110, target=0110 -> four DRIVE cycles of all-zero j/k; done in cycle 6; err=0.
REQ-034 q_fb[2] stuck at 0, target=0100 -> done with err=1.
REQ-035 start pulsed during DRIVE -> ignored; start held during the done cycle -> new DRIVE begins next cycle.
REQ-036 rst asserted in DRIVE at idx=2 -> j=k=0 that cycle; next cycle IDLE, busy=0; no done pulse follows.
